outport_scheduler: RTL and testbench
====================================

OUTPORT_SCHEDULER -- requirements
Module: outport_scheduler

Interface
REQ-001 Parameter NPORTS, default 5: number of requesting input ports; index order 0=L, 1=N, 2=E, 3=W, 4=S.
REQ-002 Parameter LEN_W, default 12: width of each packet-length field.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  NPORTS  per-input flowcontrol ready, high = input holds a packet routed to this output.
REQ-006 flit_type  input  3*NPORTS  flit type at each input FIFO head; port i occupies bits [3i+2:3i].
REQ-007 len  input  LEN_W*NPORTS  body-flit count (header excluded) of each head packet; port i occupies bits [LEN_W*i +: LEN_W].
REQ-008 dcts  input  1  downstream clear-to-send.
REQ-009 grant  output  NPORTS  one-hot read enable to the winning input FIFO, one flit per high cycle.
REQ-010 sel  output  NPORTS  one-hot crossbar select, held for the whole packet.
REQ-011 obuf_en  output  1  output buffer load enable.
REQ-012 rts  output  1  request-to-send to the next router.
REQ-013 err  output  1  one-cycle pulse on a packet framing error.

Function
REQ-014 Flit type encodings SHALL be HEADER=3'b001, BODY=3'b010, TAIL=3'b100; any other value is invalid.
REQ-015 States SHALL be IDLE, HEADER, BODY.
REQ-016 In IDLE with any req high, the block SHALL pick a winner by round-robin, searching from index (ptr+1) mod NPORTS upward with wrap, and go to HEADER on the next cycle.
REQ-017 On the IDLE->HEADER transition the block SHALL latch winner index, set sel to one-hot(winner), and load cnt with len[winner].
REQ-018 In IDLE with no req high, the block SHALL stay in IDLE with grant=0 and sel=0.
REQ-019 In HEADER or BODY, grant[winner] SHALL equal dcts (combinational); all other grant bits SHALL be 0.
REQ-020 A transfer is a cycle with grant[winner]=1; with dcts=0 the state, cnt and sel SHALL hold.
REQ-021 A HEADER transfer SHALL go to BODY if cnt!=0, else to IDLE.
REQ-022 A BODY transfer SHALL decrement cnt; the transfer made when cnt==1 SHALL go to IDLE.
REQ-023 On every return to IDLE, ptr SHALL be set to winner; ptr SHALL not change otherwise.
REQ-024 obuf_en SHALL be |grant delayed by one cycle; rts SHALL equal obuf_en.
REQ-025 Once granted, a packet SHALL be locked: a req drop or a higher-priority req SHALL not preempt it.
REQ-026 During a BODY transfer, flit_type[winner]==TAIL with cnt!=1 SHALL force IDLE and pulse err for one cycle.
REQ-027 During a BODY transfer, a non-TAIL flit with cnt==1 SHALL also force IDLE and pulse err.
REQ-028 In HEADER, flit_type[winner]!=HEADER SHALL pulse err and return to IDLE without asserting grant.
REQ-029 Minimum latency SHALL be one cycle from a req rising in IDLE to the first grant (with dcts=1); a packet of len N SHALL occupy exactly N+1 transfer cycles.
REQ-030 Back-to-back packets SHALL have exactly one IDLE arbitration cycle between them.

Reset
REQ-031 While rst=1: state=IDLE, cnt=0, sel=0, grant=0, obuf_en=0, rts=0, err=0, ptr=NPORTS-1, so that index 0 (L) has first priority.
REQ-032 Reset asserted mid-packet SHALL abort the packet at once with no further grant; the first post-reset arbitration SHALL follow REQ-031 priority.

Structure
REQ-033 Flit type encodings, state encodings and port-index constants SHALL go in the shared parameters/state-defines include.
REQ-034 The round-robin winner search SHALL be one combinational sub-module, rr_pick (inputs req, ptr; output one-hot winner and valid).
REQ-035 The flit counter, state register and ptr SHALL live in outport_scheduler.

Verification
REQ-036 After reset, req=5'b10001, both len=0, dcts=1, heads HEADER -> L granted first (1 cycle), then S; ptr ends at 4.
REQ-037 req[2] only, len[2]=3, dcts=1, HEADER then 2 BODY then TAIL -> grant[2] high 4 consecutive cycles, obuf_en/rts high 4 cycles delayed by 1, err=0.
REQ-038 Same packet with dcts low for 2 cycles after the 2nd transfer -> grant drops for exactly those cycles; total transfers still 4; sel stays 5'b00100.
REQ-039 len[1]=4 but TAIL appears at the 3rd transfer -> err pulses 1 cycle, state returns to IDLE, next arbitration starts from index 2.
REQ-040 rst asserted during the 2nd BODY transfer of a len=5 packet -> all outputs 0 next cycle; after release with req=5'b11111, index 0 wins.

Source files
------------

// File: rtl/outport_scheduler_pkg.sv
// outport_scheduler_pkg: shared flit/state encodings and port indices
package outport_scheduler_pkg;
  typedef enum logic [2:0] {FLIT_HEADER = 3'b001, FLIT_BODY = 3'b010, FLIT_TAIL = 3'b100} flit_t;
  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_BODY} state_t;
  localparam int FLIT_W = 3;
  localparam int PORT_L = 0;
  localparam int PORT_N = 1;
  localparam int PORT_E = 2;
  localparam int PORT_W = 3;
  localparam int PORT_S = 4;
endpackage

// File: rtl/outport_scheduler_if.sv
// outport_scheduler_if: request/flit side and grant/output side of one output port
interface outport_scheduler_if #(parameter int NPORTS = 5, parameter int LEN_W = 12);
  logic [NPORTS-1:0] req;
  logic [3*NPORTS-1:0] flit_type;
  logic [LEN_W*NPORTS-1:0] len;
  logic dcts;
  logic [NPORTS-1:0] grant;
  logic [NPORTS-1:0] sel;
  logic obuf_en;
  logic rts;
  logic err;
  modport master (output req, flit_type, len, dcts, input grant, sel, obuf_en, rts, err);
  modport slave (input req, flit_type, len, dcts, output grant, sel, obuf_en, rts, err);
endinterface

// File: rtl/outport_scheduler_rr_pick.sv
// rr_pick: round-robin winner search starting just after ptr, with wrap
module rr_pick #(
  parameter int NPORTS = 5,
  parameter int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic [NPORTS-1:0] req_i,
  input  logic [PW-1:0]     ptr_i,
  output logic [NPORTS-1:0] win_o,
  output logic              valid_o
);
  logic [PW:0] sh;
  logic [NPORTS-1:0] rot, first;
  assign sh = {1'b0, ptr_i} + (PW+1)'(1);
  assign rot = NPORTS'({req_i, req_i} >> sh);
  assign first = rot & (~rot + NPORTS'(1));
  assign win_o = NPORTS'(({first, first} << sh) >> NPORTS);
  assign valid_o = |req_i;
endmodule

// File: rtl/outport_scheduler.sv
// outport_scheduler: wormhole output-port arbiter with packet lock and framing check
module outport_scheduler
  import outport_scheduler_pkg::*;
#(
  parameter int NPORTS = 5,
  parameter int LEN_W = 12
) (
  input logic clk,
  input logic rst,
  outport_scheduler_if.slave io
);
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  state_t state_q;
  logic [PW-1:0] ptr_q, win_q, pick_idx_d;
  logic [LEN_W-1:0] cnt_q, pick_len_d;
  logic [NPORTS-1:0] sel_q, pick_d;
  logic pick_v_d, obuf_q, err_q;
  logic [2:0] head_d;
  logic hdr_ok_d, is_tail_d, last_d, xfer_d, end_pkt_d, frame_err_d;
  rr_pick #(.NPORTS(NPORTS), .PW(PW)) u_pick (
    .req_i(io.req), .ptr_i(ptr_q), .win_o(pick_d), .valid_o(pick_v_d)
  );
  // binary index of the one-hot round-robin winner
  always_comb begin
    pick_idx_d = '0;
    for (int i = 0; i < NPORTS; i++) pick_idx_d = pick_d[i] ? PW'(i) : pick_idx_d;
  end
  assign pick_len_d = LEN_W'(io.len >> (LEN_W * pick_idx_d));
  assign head_d = 3'(io.flit_type >> (FLIT_W * win_q));
  assign hdr_ok_d = head_d == FLIT_HEADER;
  assign is_tail_d = head_d == FLIT_TAIL;
  assign last_d = cnt_q == LEN_W'(1);
  assign xfer_d = io.dcts & ~rst & ((state_q == S_BODY) | (state_q == S_HEADER & hdr_ok_d));
  assign end_pkt_d = (state_q == S_HEADER & (~hdr_ok_d | (io.dcts & cnt_q == '0)))
                   | (state_q == S_BODY & io.dcts & (last_d | is_tail_d));
  assign frame_err_d = (state_q == S_HEADER & ~hdr_ok_d)
                     | (state_q == S_BODY & io.dcts & (is_tail_d ^ last_d));
  assign io.grant = xfer_d ? sel_q : '0;
  assign io.sel = rst ? '0 : sel_q;
  assign io.obuf_en = obuf_q & ~rst;
  assign io.rts = obuf_q & ~rst;
  assign io.err = err_q & ~rst;
  // packet FSM: arbitrate in IDLE, then stay locked on the winner until tail or framing error
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q <= PW'(NPORTS - 1);
      win_q <= '0;
      cnt_q <= '0;
      sel_q <= '0;
      obuf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      obuf_q <= xfer_d;
      err_q <= frame_err_d;
      if (state_q == S_IDLE && pick_v_d) begin
        state_q <= S_HEADER;
        win_q <= pick_idx_d;
        sel_q <= pick_d;
        cnt_q <= pick_len_d;
      end else if (end_pkt_d) begin
        state_q <= S_IDLE;
        ptr_q <= win_q;
        sel_q <= '0;
        cnt_q <= '0;
      end else if (xfer_d) begin
        state_q <= S_BODY;
        cnt_q <= (state_q == S_BODY) ? cnt_q - LEN_W'(1) : cnt_q;
      end
    end
  end
endmodule

// File: tb/tb_outport_scheduler.sv
// tb_outport_scheduler: directed vector table, latency probe and randomized run against a packet-level model
module tb_outport_scheduler;
  localparam int N = 5;
  localparam int LW = 12;
  localparam logic [2:0] H = 3'b001, B = 3'b010, T = 3'b100;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  outport_scheduler_if #(.NPORTS(N), .LEN_W(LW)) io();
  outport_scheduler #(.NPORTS(N), .LEN_W(LW)) dut (.clk(clk), .rst(rst), .io(io));
  int checks = 0;
  int failures = 0;
  typedef struct packed {
    logic r;
    logic [N-1:0] req;
    logic [3*N-1:0] f;
    logic [LW*N-1:0] l;
    logic d;
    logic [N-1:0] g;
    logic [N-1:0] s;
    logic o;
    logic e;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [3*N-1:0] ft(int p, logic [2:0] t);
    return (3*N)'(t) << (3 * p);
  endfunction
  function automatic logic [LW*N-1:0] ln(int p, int n);
    return (LW*N)'(n) << (LW * p);
  endfunction
  task automatic add(logic r, logic [N-1:0] q, logic [3*N-1:0] f, logic [LW*N-1:0] l, logic d,
                     logic [N-1:0] g, logic [N-1:0] s, logic o, logic e);
    tbl.push_back(vec_t'{r, q, f, l, d, g, s, o, e});
  endtask
  task automatic drive(logic r, logic [N-1:0] q, logic [3*N-1:0] f, logic [LW*N-1:0] l, logic d);
    rst = r;
    io.req = q;
    io.flit_type = f;
    io.len = l;
    io.dcts = d;
  endtask
  // packet-level reference model state
  bit m_busy, m_hdr, m_obuf, m_err;
  int m_own, m_left, m_ptr;
  initial begin
    logic [3*N-1:0] allh, fa;
    logic [LW*N-1:0] l0, l1, l2;
    int lat;
    bit got;
    drive(1, '0, '0, '0, 1);
    allh = '0;
    for (int p = 0; p < N; p++) allh |= ft(p, H);
    fa = ft(0, H) | ft(4, H);
    l0 = ln(0, 5);
    l1 = ln(1, 4);
    l2 = ln(2, 3);
    // L and S both ready with header-only packets: L first, then S, then ptr=4 gives L again
    add(1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 5'b10001, fa, 0, 1, 0, 0, 0, 0);
    add(0, 5'b10001, fa, 0, 1, 5'b00001, 5'b00001, 0, 0);
    add(0, 5'b10001, fa, 0, 1, 0, 0, 1, 0);
    add(0, 5'b10001, fa, 0, 1, 5'b10000, 5'b10000, 0, 0);
    add(0, 5'b10001, fa, 0, 1, 0, 0, 1, 0);
    add(0, 0, fa, 0, 1, 5'b00001, 5'b00001, 0, 0);
    add(0, 0, fa, 0, 1, 0, 0, 1, 0);
    add(0, 0, fa, 0, 1, 0, 0, 0, 0);
    // E, len 3, full packet; req drops on the tail but the packet stays locked
    add(1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 5'b00100, ft(2, H), l2, 1, 0, 0, 0, 0);
    add(0, 5'b00100, ft(2, H), l2, 1, 5'b00100, 5'b00100, 0, 0);
    add(0, 5'b00100, ft(2, B), l2, 1, 5'b00100, 5'b00100, 1, 0);
    add(0, 5'b00100, ft(2, B), l2, 1, 5'b00100, 5'b00100, 1, 0);
    add(0, 0, ft(2, T), l2, 1, 5'b00100, 5'b00100, 1, 0);
    add(0, 0, 0, l2, 1, 0, 0, 1, 0);
    add(0, 0, 0, l2, 1, 0, 0, 0, 0);
    // same packet with dcts low for two cycles after the second transfer
    add(1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 5'b00100, ft(2, H), l2, 1, 0, 0, 0, 0);
    add(0, 5'b00100, ft(2, H), l2, 1, 5'b00100, 5'b00100, 0, 0);
    add(0, 5'b00100, ft(2, B), l2, 1, 5'b00100, 5'b00100, 1, 0);
    add(0, 5'b00100, ft(2, B), l2, 0, 0, 5'b00100, 1, 0);
    add(0, 5'b00100, ft(2, B), l2, 0, 0, 5'b00100, 0, 0);
    add(0, 5'b00100, ft(2, B), l2, 1, 5'b00100, 5'b00100, 0, 0);
    add(0, 5'b00100, ft(2, T), l2, 1, 5'b00100, 5'b00100, 1, 0);
    add(0, 0, 0, l2, 1, 0, 0, 1, 0);
    add(0, 0, 0, l2, 1, 0, 0, 0, 0);
    // N, len 4, early tail on the 3rd transfer; next arbitration starts at E
    add(1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 5'b00010, ft(1, H), l1, 1, 0, 0, 0, 0);
    add(0, 5'b00010, ft(1, H), l1, 1, 5'b00010, 5'b00010, 0, 0);
    add(0, 5'b00010, ft(1, B), l1, 1, 5'b00010, 5'b00010, 1, 0);
    add(0, 5'b00010, ft(1, T), l1, 1, 5'b00010, 5'b00010, 1, 0);
    add(0, 5'b11111, allh, l1, 1, 0, 0, 1, 1);
    add(0, 0, allh, l1, 1, 5'b00100, 5'b00100, 0, 0);
    add(0, 0, allh, l1, 1, 0, 0, 1, 0);
    // reset during the 2nd body transfer of a len-5 packet, then L wins among all
    add(1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 5'b00001, ft(0, H), l0, 1, 0, 0, 0, 0);
    add(0, 5'b00001, ft(0, H), l0, 1, 5'b00001, 5'b00001, 0, 0);
    add(0, 5'b00001, ft(0, B), l0, 1, 5'b00001, 5'b00001, 1, 0);
    add(1, 5'b00001, ft(0, B), l0, 1, 0, 0, 0, 0);
    add(0, 5'b11111, allh, 0, 1, 0, 0, 0, 0);
    add(0, 0, allh, 0, 1, 5'b00001, 5'b00001, 0, 0);
    add(0, 0, allh, 0, 1, 0, 0, 1, 0);
    // W presents a body flit where a header is due: err, no grant
    add(1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 5'b01000, ft(3, B), 0, 1, 0, 0, 0, 0);
    add(0, 5'b01000, ft(3, B), 0, 1, 0, 5'b01000, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    // L, len 1, body flit instead of tail on the last transfer
    add(1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 5'b00001, ft(0, H), ln(0, 1), 1, 0, 0, 0, 0);
    add(0, 5'b00001, ft(0, H), ln(0, 1), 1, 5'b00001, 5'b00001, 0, 0);
    add(0, 5'b00001, ft(0, B), ln(0, 1), 1, 5'b00001, 5'b00001, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].r, tbl[i].req, tbl[i].f, tbl[i].l, tbl[i].d);
      #1;
      chk($sformatf("row%0d grant", i), 32'(io.grant), 32'(tbl[i].g));
      chk($sformatf("row%0d sel", i), 32'(io.sel), 32'(tbl[i].s));
      chk($sformatf("row%0d obuf_en", i), 32'(io.obuf_en), 32'(tbl[i].o));
      chk($sformatf("row%0d rts", i), 32'(io.rts), 32'(tbl[i].o));
      chk($sformatf("row%0d err", i), 32'(io.err), 32'(tbl[i].e));
    end
    // first grant arrives one cycle after req rises in IDLE
    @(negedge clk);
    drive(1, '0, '0, '0, 1);
    @(negedge clk);
    drive(0, 5'b01000, ft(3, H), '0, 1);
    lat = 0;
    got = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      lat++;
      if (io.grant != '0) begin
        got = 1;
        break;
      end
    end
    chk("latency cycles", got ? 32'(lat) : 32'hdead, 32'd1);
    chk("latency grant", 32'(io.grant), 32'(5'b01000));
    // randomized run against the packet-level model
    m_busy = 0; m_hdr = 0; m_obuf = 0; m_err = 0; m_own = 0; m_left = 0; m_ptr = N - 1;
    for (int it = 0; it < 4000; it++) begin
      logic [2:0] ty[N];
      int lens[N];
      logic [N-1:0] rq, eg, es;
      logic [3*N-1:0] fv;
      logic [LW*N-1:0] lv;
      logic r, d;
      logic [2:0] oft;
      @(negedge clk);
      r = (it == 0) || ($urandom_range(0, 199) == 0);
      rq = N'($urandom);
      d = $urandom_range(0, 3) != 0;
      fv = '0;
      lv = '0;
      for (int p = 0; p < N; p++) begin
        case ($urandom_range(0, 3))
          0: ty[p] = H;
          1: ty[p] = B;
          2: ty[p] = T;
          default: ty[p] = 3'($urandom_range(0, 7));
        endcase
        if (m_busy && p == m_own && $urandom_range(0, 9) != 0)
          ty[p] = m_hdr ? H : (m_left == 1 ? T : B);
        lens[p] = $urandom_range(0, 4);
        fv |= ft(p, ty[p]);
        lv |= ln(p, lens[p]);
      end
      drive(r, rq, fv, lv, d);
      #1;
      oft = ty[m_own];
      eg = (!r && m_busy && d && (!m_hdr || oft == H)) ? N'(1) << m_own : '0;
      es = (!r && m_busy) ? N'(1) << m_own : '0;
      chk($sformatf("rand cycle %0d {grant,sel,obuf_en,rts,err}", it),
          32'({io.grant, io.sel, io.obuf_en, io.rts, io.err}),
          32'({eg, es, !r && m_obuf, !r && m_obuf, !r && m_err}));
      if (r) begin
        m_busy = 0; m_obuf = 0; m_err = 0; m_ptr = N - 1;
      end else begin
        m_obuf = eg != '0;
        m_err = 0;
        if (!m_busy) begin
          if (rq != '0) begin
            for (int k = 1; k <= N; k++)
              if (rq[(m_ptr + k) % N]) begin
                m_own = (m_ptr + k) % N;
                break;
              end
            m_busy = 1; m_hdr = 1; m_left = lens[m_own];
          end
        end else if (m_hdr) begin
          if (oft != H) begin
            m_err = 1; m_busy = 0; m_ptr = m_own;
          end else if (d) begin
            m_hdr = 0;
            if (m_left == 0) begin
              m_busy = 0; m_ptr = m_own;
            end
          end
        end else if (d) begin
          if (oft == T || m_left == 1) begin
            m_err = (oft == T) != (m_left == 1); m_busy = 0; m_ptr = m_own;
          end else m_left--;
        end
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
